// File: rtl/keycode_slot_tracker.sv
// Turns keyboard make/break events into four compacted, duplicate-free held-key slots in press order.
// Optional build macro KEYSLOT_SNAPSHOT_EN: slot outputs and held_count refresh only on frame_tick.
module keycode_slot_tracker #(
    parameter int SLOTS = 4
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [7:0] ev_code,
    input  logic       ev_press,
    input  logic       frame_tick,
    output logic [7:0] keycode_0,
    output logic [7:0] keycode_1,
    output logic [7:0] keycode_2,
    output logic [7:0] keycode_3,
    output logic [2:0] held_count,
    output logic       overflow
);

    // state  | meaning
    // IDLE   | ready for the next key event
    // LOOKUP | search the held table for the captured code
    // UPDATE | insert, remove or ignore the captured code
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [2:0] FULL = 3'(SLOTS);

    state_t     state;
    state_t     state_nxt;
    logic       accept;

    logic [7:0] code_q;
    logic       press_q;
    logic       hit_q;
    logic [1:0] idx_q;
    logic       hit_c;
    logic [1:0] idx_c;

    logic [7:0] slot     [SLOTS];
    logic [7:0] slot_nxt [SLOTS];
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       ovf;
    logic       ovf_nxt;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev_ready = (state == IDLE);
        accept   = ev_valid & ev_ready;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            code_q  <= 8'h00;
            press_q <= 1'b0;
        end else if (accept) begin
            code_q  <= ev_code;
            press_q <= ev_press;
        end
    end

    // Scan from the top down so the lowest matching slot wins.
    always_comb begin
        hit_c = 1'b0;
        idx_c = 2'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if ((3'(i) < cnt) && (slot[i] == code_q)) begin
                hit_c = 1'b1;
                idx_c = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q <= 1'b0;
            idx_q <= 2'd0;
        end else if (state == LOOKUP) begin
            hit_q <= hit_c;
            idx_q <= idx_c;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slot_nxt[i] = slot[i];
        end
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if ((state == UPDATE) && (code_q != 8'h00)) begin
            if (press_q) begin
                if (!hit_q) begin
                    if (cnt < FULL) begin
                        slot_nxt[cnt[1:0]] = code_q;
                        cnt_nxt            = cnt + 3'd1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end else if (hit_q) begin
                // Close the gap so the remaining keys keep their press order.
                for (int j = 0; j < SLOTS - 1; j++) begin
                    if (2'(j) >= idx_q) begin
                        slot_nxt[j] = slot[j+1];
                    end
                end
                slot_nxt[SLOTS-1] = 8'h00;
                cnt_nxt           = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    ovf_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot[i] <= 8'h00;
            end
            cnt <= 3'd0;
            ovf <= 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                slot[i] <= slot_nxt[i];
            end
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    assign overflow = ovf;

`ifdef KEYSLOT_SNAPSHOT_EN
    logic [7:0] snap [SLOTS];
    logic [2:0] snap_cnt;

    // Loaded from the pre-edge table, so an update landing on the tick waits for the next frame.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                snap[i] <= 8'h00;
            end
            snap_cnt <= 3'd0;
        end else if (frame_tick) begin
            for (int i = 0; i < SLOTS; i++) begin
                snap[i] <= slot[i];
            end
            snap_cnt <= cnt;
        end
    end

    assign keycode_0  = snap[0];
    assign keycode_1  = snap[1];
    assign keycode_2  = snap[2];
    assign keycode_3  = snap[3];
    assign held_count = snap_cnt;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;

    assign keycode_0  = slot[0];
    assign keycode_1  = slot[1];
    assign keycode_2  = slot[2];
    assign keycode_3  = slot[3];
    assign held_count = cnt;
`endif

endmodule
